spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI receive endpoint matching the team's 12-bit SPI master: deserialises MOSI frames into parallel words.
//  Frame format: cs low, LSB first, MOSI changes on sclk rising edge, sampled here on sclk falling edge.
//  sclk/cs/mosi arrive asynchronous to clk; all are synchronised and oversampled in the clk domain.
//  Sits on the peripheral side; dout/done feed the register or FIFO logic behind it.
// PARAMETERS
//  DATA_WIDTH   12  bits per frame; also the width of dout
//  SYNC_STAGES  2   flop stages on each of sclk, cs, mosi (>=2)
// PORTS
//  clk        in   1           system clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  sclk       in   1           SPI serial clock from master (async)
//  cs         in   1           chip select from master, active low (async)
//  mosi       in   1           serial data from master (async)
//  dout       out  DATA_WIDTH  last complete received word
//  done       out  1           one-clk pulse: dout updated with a new word
//  frame_err  out  1           one-clk pulse: cs deasserted before DATA_WIDTH bits
//  busy       out  1           high while a frame is in progress (RECV or HOLD)
// BEHAVIOUR
//  Reset (rst_n low, async): dout=0, done=0, frame_err=0, busy=0, state=IDLE, bit_cnt=0, shift reg=0;
//   sync chains preset: sclk->0, cs->1, mosi->0. Outputs update only on clk rising edge after release.
//  Sync: SYNC_STAGES flops per input plus one history flop on sclk and cs; sclk_fall = prev & ~cur;
//   cs_rise = ~prev & cur. All decisions use synchronised values only.
//  Input timing: each sclk level held >= SYNC_STAGES+2 clk cycles; shorter pulses are not supported.
//  FSM states:
//   IDLE: busy=0. cs_sync low -> RECV, bit_cnt=0, shift reg cleared.
//   RECV: busy=1. On sclk_fall with cs_sync low: shift reg[bit_cnt] <= mosi_sync, bit_cnt++.
//     When bit DATA_WIDTH-1 is captured (same clk edge): dout <= completed word, done=1 next cycle only,
//     -> HOLD. On cs_rise with bit_cnt < DATA_WIDTH: frame_err pulse 1 clk, dout unchanged, -> IDLE.
//   HOLD: busy=1. Further sclk_fall edges ignored (no shift, no done). cs_rise -> IDLE, no error.
//  Latency: done rises SYNC_STAGES+2 clk cycles (+/-1 for async sampling) after the 12th physical sclk fall.
//  sclk_fall and cs_rise in the same clk cycle in RECV: cs_rise wins; bit not captured; frame_err if count short.
//  cs falling and sclk_fall in the same cycle in IDLE: edge not sampled (frame starts next cycle).
//  sclk activity while cs_sync high: ignored in every state.
//  done and frame_err never asserted in the same cycle; each is exactly one clk wide.
//  bit_cnt width = $clog2(DATA_WIDTH+1); never exceeds DATA_WIDTH.
//  dout holds its value until the next done or reset.
// TESTING
//  1 Frame 12'hA5C, LSB first, sclk half-period 11 clk -> exactly one done pulse, dout=12'hA5C, frame_err=0.
//  2 Back-to-back frames 12'h001 then 12'hFFF, cs high 2 sclk periods between -> two done pulses, dout 001 then FFF.
//  3 cs raised after 5 bits of 12'h7E1 -> frame_err 1-clk pulse, no done, dout retains previous word, busy drops.
//  4 rst_n low for 3 clk after 6 bits -> all outputs 0 immediately; next frame 12'h3C3 -> dout=12'h3C3.
//  5 Frame 12'h555 then 3 extra sclk edges before cs high -> one done only, dout=12'h555, no frame_err.
//  6 sclk toggling 8 periods with cs high, mosi=1 -> done, frame_err, busy stay 0; dout unchanged.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: synchronises sclk/cs/mosi into clk, deserialises LSB-first frames
// sampled on sclk falling edges, and reports complete words (done) or short frames (frame_err).
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_p0;
  logic [SYNC_STAGES-1:0] cs_sync_p0;
  logic [SYNC_STAGES-1:0] mosi_sync_p0;
  logic                   sclk_prev_p1;
  logic                   cs_prev_p1;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_fall;
  logic                   cs_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Stage p0: synchroniser chains; cs presets high so reset looks like "not selected"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_p0 <= '0;
      cs_sync_p0   <= '1;
      mosi_sync_p0 <= '0;
    end else begin
      sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], sclk};
      cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], cs};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_sync_p0[SYNC_STAGES-1];
  assign cs_s   = cs_sync_p0[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];

  // Stage p1: history flops for edge detection on the synchronised levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_p1 <= 1'b0;
      cs_prev_p1   <= 1'b1;
    end else begin
      sclk_prev_p1 <= sclk_s;
      cs_prev_p1   <= cs_s;
    end
  end

  assign sclk_fall = sclk_prev_p1 & ~sclk_s;
  assign cs_rise   = ~cs_prev_p1 & cs_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d   = RECV;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end

      RECV: begin
        // A closing cs edge takes priority over a coincident sclk edge
        if (cs_rise) begin
          err_d   = (bit_cnt_q < CNT_W'(DATA_WIDTH));
          state_d = IDLE;
        end else if (sclk_fall && !cs_s) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_q == CNT_W'(i)) shreg_d[i] = mosi_s;
          end
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            dout_d  = shreg_d;
            done_d  = 1'b1;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (cs_rise) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Stage p2: frame state, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives LSB-first frames with an 11-clk sclk half-period
// and checks done/frame_err pulses, captured words and busy against hand-computed values.
module tb_spi_slave_rx;

  localparam int DW   = 12;
  localparam int HALF = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sclk;
  logic          cs;
  logic          mosi;
  logic [DW-1:0] dout;
  logic          done;
  logic          frame_err;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  int done_cnt    = 0;
  int err_cnt     = 0;
  int wide_cnt    = 0;
  int overlap_cnt = 0;
  logic done_last = 1'b0;
  logic err_last  = 1'b0;
  logic [DW-1:0] words[$];

  spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .dout     (dout),
    .done     (done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt = done_cnt + 1;
        words.push_back(dout);
        if (done_last) wide_cnt = wide_cnt + 1;
      end
      if (frame_err) begin
        err_cnt = err_cnt + 1;
        if (err_last) wide_cnt = wide_cnt + 1;
      end
      if (done && frame_err) overlap_cnt = overlap_cnt + 1;
    end
    done_last = done;
    err_last  = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      sclk = 1'b1;
      mosi = w[i];
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
    end
  endtask

  task automatic frame(input logic [DW-1:0] w, input int extra);
    cs = 1'b0;
    wait_clk(HALF);
    send_bits(w, 0, DW - 1);
    for (int i = 0; i < extra; i++) begin
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    cs = 1'b1;
    wait_clk(4 * HALF);
  endtask

  initial begin
    int d0, e0, w0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs    = 1'b1;
    mosi  = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // 1: single frame 12'hA5C
    d0 = done_cnt; e0 = err_cnt; w0 = words.size();
    cs = 1'b0;
    wait_clk(HALF);
    send_bits(12'hA5C, 0, 5);
    check("t1_busy_mid", 32'(busy), 32'h1);
    send_bits(12'hA5C, 6, DW - 1);
    wait_clk(HALF);
    check("t1_busy_hold", 32'(busy), 32'h1);
    cs = 1'b1;
    wait_clk(4 * HALF);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_word", 32'(words[w0]), 32'hA5C);
    check("t1_dout", 32'(dout), 32'hA5C);
    check("t1_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("t1_busy_end", 32'(busy), 32'h0);

    // 2: back-to-back frames
    d0 = done_cnt; e0 = err_cnt; w0 = words.size();
    frame(12'h001, 0);
    frame(12'hFFF, 0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("t2_word0", 32'(words[w0]), 32'h001);
    check("t2_word1", 32'(words[w0 + 1]), 32'hFFF);
    check("t2_err_cnt", 32'(err_cnt - e0), 32'd0);

    // 3: short frame, cs raised after 5 bits
    d0 = done_cnt; e0 = err_cnt;
    cs = 1'b0;
    wait_clk(HALF);
    send_bits(12'h7E1, 0, 4);
    cs = 1'b1;
    wait_clk(4 * HALF);
    check("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("t3_dout", 32'(dout), 32'hFFF);
    check("t3_busy", 32'(busy), 32'h0);

    // 4: async reset mid-frame, then a clean frame
    cs = 1'b0;
    wait_clk(HALF);
    send_bits(12'h0F0, 0, 5);
    check("t4_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_dout", 32'(dout), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_done", 32'(done), 32'h0);
    check("t4_rst_err", 32'(frame_err), 32'h0);
    cs   = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    d0 = done_cnt; e0 = err_cnt; w0 = words.size();
    frame(12'h3C3, 0);
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t4_dout", 32'(dout), 32'h3C3);
    check("t4_err_cnt", 32'(err_cnt - e0), 32'd0);

    // 5: extra sclk edges after a full frame are ignored
    d0 = done_cnt; e0 = err_cnt; w0 = words.size();
    frame(12'h555, 3);
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t5_word", 32'(words[w0]), 32'h555);
    check("t5_dout", 32'(dout), 32'h555);
    check("t5_err_cnt", 32'(err_cnt - e0), 32'd0);

    // 6: sclk activity with cs high
    d0 = done_cnt; e0 = err_cnt;
    mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b1;
      wait_clk(HALF);
      check("t6_busy", 32'(busy), 32'h0);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    wait_clk(10);
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("t6_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("t6_dout", 32'(dout), 32'h555);

    check("pulse_width", 32'(wide_cnt), 32'd0);
    check("pulse_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
